fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Line-based instruction fetch front end: issues sysbus line reads and unpacks each beat into
//  INSN_PER_BEAT instructions with their PCs. Buffers them in an instruction FIFO and presents
//  them to decode via valid/ready. Supports redirect (flush + refetch) and halt on a zero word.
// PARAMETERS
//  BUS_DATA_WIDTH  64  sysbus data width (multiple of INSN_WIDTH)
//  BUS_TAG_WIDTH   13  sysbus tag width
//  INSN_WIDTH      32  instruction width; fixed 4-byte PC stride
//  LINE_BYTES      64  bytes per bus read request (power of two)
//  FIFO_DEPTH      16  instruction FIFO entries; power of two, >= LINE_INSNS
//  derived: INSN_PER_BEAT=BUS_DATA_WIDTH/INSN_WIDTH, BEATS=LINE_BYTES*8/BUS_DATA_WIDTH, LINE_INSNS=INSN_PER_BEAT*BEATS
// PORTS
//  clk             in   1               clock
//  reset           in   1               asynchronous, active-low reset
//  entry           in   64              program entry PC, loaded while reset asserted
//  bus_reqcyc      out  1               request valid
//  bus_reqack      in   1               request accepted
//  bus_req         out  BUS_DATA_WIDTH  line-aligned read address
//  bus_reqtag      out  BUS_TAG_WIDTH   SYSBUS_READ<<12 | SYSBUS_MEMORY<<8
//  bus_respcyc     in   1               response beat valid
//  bus_respack     out  1               response beat consumed
//  bus_resp        in   BUS_DATA_WIDTH  response beat data
//  bus_resptag     in   BUS_TAG_WIDTH   response tag (unused; single outstanding request)
//  redirect_valid  in   1               flush and restart fetch at redirect_pc
//  redirect_pc     in   64              new PC; bits[1:0] ignored
//  out_valid       out  1               out_insn/out_pc valid
//  out_ready       in   1               decode accepts when out_valid&&out_ready
//  out_insn        out  INSN_WIDTH      instruction
//  out_pc          out  64              instruction address
//  halt            out  1               zero instruction reached FIFO head
// BEHAVIOUR
//  - Reset (reset==0, async): state=IDLE, fetch_pc=entry, FIFO empty, beat_cnt=0. All outputs 0 except bus_reqtag (constant).
//  - FSM IDLE->REQ when FIFO free entries >= LINE_INSNS and not halted. A whole line is reserved, so the FIFO never overflows.
//  - REQ: bus_reqcyc=1, bus_req={fetch_pc[63:log2(LINE_BYTES)],0}. Held stable until bus_reqack=1, then ->RESP; reqcyc drops next cycle.
//  - RESP: bus_respack = bus_respcyc (combinational); each cycle with respcyc=1 consumes one beat.
//    Lane i = bus_resp[i*INSN_WIDTH +: INSN_WIDTH]; its PC = line_addr + (beat_cnt*INSN_PER_BEAT+i)*4; low lane first.
//  - Lanes with PC < fetch_pc (mid-line entry/redirect) are discarded; remaining lanes are pushed in order, up to INSN_PER_BEAT per cycle.
//  - After beat BEATS-1: beat_cnt=0, fetch_pc = line_addr+LINE_BYTES (wraps mod 2^64), ->IDLE. Request latency 1 cycle from IDLE.
//  - Zero word pushed: later lanes/beats of the line are acked but not pushed, then ->HALTED (no further requests).
//    halt=1 while the zero word is at FIFO head; out_valid forced 0 in that case; sticky until reset/redirect.
//  - Output: out_valid = FIFO non-empty && !halt. out_insn/out_pc hold stable while out_valid && !out_ready. Pop and push in the same cycle are allowed.
//  - redirect_valid (priority over push/pop/bus events that cycle):
//    FIFO flushed (out_valid=0 next cycle); halt cleared; fetch_pc=redirect_pc&~3.
//    From REQ: finish the handshake, then drain. From RESP: ->DRAIN, ack and discard remaining beats, then ->IDLE.
//    From IDLE/HALTED: ->IDLE. Redirect during DRAIN updates fetch_pc only.
//  - Exactly one request outstanding; bus_resptag is not checked.
// STRUCTURE
//  - fetch_pkg: state enum {IDLE,REQ,RESP,DRAIN,HALTED}, FETCH_REQ_TAG constant, derived-width localparam functions.
//  - Sub-module fetch_fifo: sync FIFO, width INSN_WIDTH+64, push up to INSN_PER_BEAT lanes (per-lane enables) per cycle,
//    single pop, flush, count output.
//  - fetch_unit holds the FSM, address/beat counters, lane filter, and the bus interface.
// TESTING
//  1. entry=0x1000, mem[i]=0x13+i, out_ready=1: bus_req=0x1000, 8 beats -> 16 insns out, pc 0x1000..0x103C, insn 0x13..0x22 in order; next bus_req=0x1040.
//  2. entry=0x1008: bus_req=0x1000; first out_pc=0x1008; 14 insns delivered from that line.
//  3. out_ready=0 after line 1: FIFO count=16, bus_reqcyc stays 0 for 100 cycles; out_ready=1 -> request 0x1040 once count<=0.
//  4. redirect_pc=0x2006 after beat 3 of line 0x1000: out_valid=0 next cycle, 5 beats acked and discarded, bus_req=0x2000, first out_pc=0x2004.
//  5. mem word at 0x1010 = 0: 4 insns out, then halt=1, out_valid=0, no further bus_reqcyc; redirect to 0x3000 clears halt and fetches.
//  6. reset pulled low mid-RESP: bus_reqcyc/bus_respack/out_valid/halt=0 immediately; after release, bus_req=entry line.

Source files
------------

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared state type, request tag and width helpers for the fetch front end
package fetch_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        RESP,
        DRAIN,
        HALTED
    } fetch_state_t;

    localparam int SYSBUS_READ   = 1;
    localparam int SYSBUS_MEMORY = 1;
    localparam logic [12:0] FETCH_REQ_TAG = (13'(SYSBUS_READ) << 12) | (13'(SYSBUS_MEMORY) << 8);

    // Counter width that stays legal when a line is a single beat.
    function automatic int clog2_min1(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

    function automatic int insn_per_beat(input int bus_w, input int insn_w);
        return bus_w / insn_w;
    endfunction

    function automatic int beats_per_line(input int line_bytes, input int bus_w);
        return (line_bytes * 8) / bus_w;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - instruction FIFO with multi-lane push, single pop and flush
module fetch_fifo #(
    parameter int WIDTH = 96,
    parameter int DEPTH = 16,
    parameter int LANES = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          flush,
    input  logic [LANES-1:0]              push_en,
    input  logic [LANES-1:0][WIDTH-1:0]   push_data,
    input  logic                          pop,
    output logic [WIDTH-1:0]              head,
    output logic [$clog2(DEPTH):0]        count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0]           mem [DEPTH];
    logic [AW-1:0]              rd_ptr;
    logic [AW-1:0]              wr_ptr;
    logic [LANES-1:0][AW-1:0]   wr_idx;
    logic [CW-1:0]              push_cnt;
    logic                       do_pop;

    // Enabled lanes are packed into consecutive slots in lane order.
    always_comb begin
        push_cnt = '0;
        for (int i = 0; i < LANES; i++) begin
            wr_idx[i] = wr_ptr + push_cnt[AW-1:0];
            push_cnt  = push_cnt + CW'(push_en[i]);
        end
    end

    assign do_pop = pop && (count != '0);
    assign head   = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + push_cnt[AW-1:0];
            rd_ptr <= rd_ptr + AW'(do_pop);
            count  <= count + push_cnt - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (push_en[i] && !flush) begin
                mem[wr_idx[i]] <= push_data[i];
            end
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - line-based instruction fetch: sysbus line reads unpacked into a decode FIFO
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int INSN_WIDTH     = 32,
    parameter int LINE_BYTES     = 64,
    parameter int FIFO_DEPTH     = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [63:0]               entry,
    output logic                      bus_reqcyc,
    input  logic                      bus_reqack,
    output logic [BUS_DATA_WIDTH-1:0] bus_req,
    output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    input  logic                      bus_respcyc,
    output logic                      bus_respack,
    input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
    input  logic                      redirect_valid,
    input  logic [63:0]               redirect_pc,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [INSN_WIDTH-1:0]     out_insn,
    output logic [63:0]               out_pc,
    output logic                      halt
);
    localparam int IPB        = insn_per_beat(BUS_DATA_WIDTH, INSN_WIDTH);
    localparam int BEATS      = beats_per_line(LINE_BYTES, BUS_DATA_WIDTH);
    localparam int LINE_INSNS = IPB * BEATS;
    localparam int LOB        = $clog2(LINE_BYTES);
    localparam int BW         = clog2_min1(BEATS);
    localparam int CW         = $clog2(FIFO_DEPTH) + 1;
    localparam int EW         = INSN_WIDTH + 64;

    fetch_state_t              state, state_n;
    logic [63:0]               fetch_pc;
    logic [63:0]               line_addr;
    logic [BW-1:0]             beat_cnt;
    logic                      zero_seen;
    logic                      drain_pend;
    logic                      zero_hit;
    logic                      beat_take;
    logic                      last_beat;
    logic                      pop;
    logic [IPB-1:0]            push_en;
    logic [IPB-1:0][EW-1:0]    push_data;
    logic [EW-1:0]             head;
    logic [CW-1:0]             count;
    logic                      unused_inputs;

    assign unused_inputs = ^{bus_resptag, redirect_pc[1:0]};

    assign beat_take   = bus_respcyc && (state == RESP || state == DRAIN);
    assign last_beat   = beat_take && (beat_cnt == BW'(BEATS - 1));
    assign bus_respack = beat_take;
    assign bus_reqcyc  = (state == REQ);
    assign bus_req     = bus_reqcyc ? BUS_DATA_WIDTH'(line_addr) : '0;
    assign bus_reqtag  = BUS_TAG_WIDTH'(FETCH_REQ_TAG);

    // A zero word parked at the head stops decode until a redirect flushes it.
    assign halt      = (count != '0) && (head[EW-1:64] == '0);
    assign out_valid = (count != '0) && !halt;
    assign out_insn  = out_valid ? head[EW-1:64] : '0;
    assign out_pc    = out_valid ? head[63:0] : '0;
    assign pop       = out_valid && out_ready;

    // Lane filter: skip lanes before fetch_pc, stop after the first zero word of the line.
    always_comb begin
        logic                  stop;
        logic [63:0]           lane_pc;
        logic [INSN_WIDTH-1:0] lane_insn;
        stop      = zero_seen;
        zero_hit  = 1'b0;
        push_en   = '0;
        push_data = '0;
        lane_pc   = '0;
        lane_insn = '0;
        for (int i = 0; i < IPB; i++) begin
            lane_pc      = line_addr + ((64'(beat_cnt) * 64'(IPB) + 64'(i)) << 2);
            lane_insn    = bus_resp[i*INSN_WIDTH +: INSN_WIDTH];
            push_data[i] = {lane_insn, lane_pc};
            if (state == RESP && bus_respcyc && !redirect_valid && !stop && lane_pc >= fetch_pc) begin
                push_en[i] = 1'b1;
                if (lane_insn == '0) begin
                    stop     = 1'b1;
                    zero_hit = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (!redirect_valid && count <= CW'(FIFO_DEPTH - LINE_INSNS)) begin
                    state_n = REQ;
                end
            end
            REQ: begin
                if (bus_reqack) begin
                    state_n = (drain_pend || redirect_valid) ? DRAIN : RESP;
                end
            end
            RESP: begin
                if (last_beat) begin
                    state_n = (!redirect_valid && (zero_seen || zero_hit)) ? HALTED : IDLE;
                end else if (redirect_valid) begin
                    state_n = DRAIN;
                end
            end
            DRAIN: begin
                if (last_beat) begin
                    state_n = IDLE;
                end
            end
            HALTED: begin
                if (redirect_valid) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            fetch_pc   <= entry;
            line_addr  <= '0;
            beat_cnt   <= '0;
            zero_seen  <= 1'b0;
            drain_pend <= 1'b0;
        end else begin
            state      <= state_n;
            drain_pend <= (state == REQ) && !bus_reqack && (drain_pend || redirect_valid);
            if (beat_take) begin
                beat_cnt <= last_beat ? '0 : beat_cnt + BW'(1);
            end
            if (state == IDLE && state_n == REQ) begin
                line_addr <= {fetch_pc[63:LOB], {LOB{1'b0}}};
                zero_seen <= 1'b0;
            end else if (zero_hit) begin
                zero_seen <= 1'b1;
            end
            if (redirect_valid) begin
                fetch_pc <= {redirect_pc[63:2], 2'b00};
            end else if (state == RESP && last_beat) begin
                fetch_pc <= line_addr + 64'(LINE_BYTES);
            end
        end
    end

    fetch_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH),
        .LANES (IPB)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect_valid),
        .push_en   (push_en),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .count     (count)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit with a sysbus memory responder
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] entry;
    logic        bus_reqcyc;
    logic        bus_reqack;
    logic [63:0] bus_req;
    logic [12:0] bus_reqtag;
    logic        bus_respcyc;
    logic        bus_respack;
    logic [63:0] bus_resp;
    logic [12:0] bus_resptag;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_insn;
    logic [63:0] out_pc;
    logic        halt;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .entry          (entry),
        .bus_reqcyc     (bus_reqcyc),
        .bus_reqack     (bus_reqack),
        .bus_req        (bus_req),
        .bus_reqtag     (bus_reqtag),
        .bus_respcyc    (bus_respcyc),
        .bus_respack    (bus_respack),
        .bus_resp       (bus_resp),
        .bus_resptag    (bus_resptag),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_insn       (out_insn),
        .out_pc         (out_pc),
        .halt           (halt)
    );

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] insn;
    } exp_t;

    exp_t        exp_q[$];
    logic [63:0] req_log[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          pops = 0;
    int          acked = 0;
    int          grant_left = 0;
    int          hold_beat = 0;
    logic        hold_on = 1'b0;
    logic        paused = 1'b0;
    logic        logged = 1'b0;
    logic [63:0] zero_addr = 64'h1;

    // Memory image: word at 0x1000 is 0x13, incrementing by one per word.
    function automatic logic [31:0] word(input logic [63:0] a);
        if (a == zero_addr) return 32'h0;
        return 32'h13 + 32'((a - 64'h1000) >> 2);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, req);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic push_exp(input logic [63:0] pc0, input int n);
        for (int k = 0; k < n; k++) begin
            exp_q.push_back('{pc: pc0 + 64'(k * 4), insn: word(pc0 + 64'(k * 4))});
        end
    endtask

    task automatic wait_q_empty(input string nm);
        int c = 0;
        while (exp_q.size() != 0 && c < 500) begin tick(); c++; end
        chk(nm, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic wait_reqs(input string nm, input int n);
        int c = 0;
        while (req_log.size() < n && c < 500) begin tick(); c++; end
        chk(nm, 64'(req_log.size() >= n), 64'd1);
    endtask

    task automatic wait_acked(input string nm, input int n);
        int c = 0;
        while (acked < n && c < 500) begin tick(); c++; end
        chk(nm, 64'(acked >= n), 64'd1);
    endtask

    task automatic wait_paused(input string nm);
        int c = 0;
        while (!paused && c < 500) begin tick(); c++; end
        chk(nm, 64'(paused), 64'd1);
    endtask

    task automatic do_reset(input logic [63:0] e);
        tick();
        reset = 1'b0;
        entry = e;
        out_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        tick();
        tick();
        exp_q.delete();
        req_log.delete();
        pops = 0;
        acked = 0;
        reset = 1'b1;
    endtask

    // Monitor: samples after inputs for the coming edge have settled.
    always @(negedge clk) begin
        exp_t e;
        #3;
        if (reset && out_valid && out_ready) begin
            pops++;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_out: got pc 0x%0h insn 0x%0h, required no output", out_pc, out_insn);
            end else begin
                e = exp_q.pop_front();
                if (out_pc !== e.pc || out_insn !== e.insn) begin
                    n_fail++;
                    $display("FAIL out_data: got pc 0x%0h insn 0x%0h, required pc 0x%0h insn 0x%0h",
                             out_pc, out_insn, e.pc, e.insn);
                end
            end
        end
    end

    // Memory responder: logs every request, grants up to grant_left of them.
    initial begin
        logic [63:0] line;
        int          b;
        bus_reqack  = 1'b0;
        bus_respcyc = 1'b0;
        bus_resp    = '0;
        bus_resptag = '0;
        forever begin
            @(negedge clk);
            if (!bus_reqcyc) logged = 1'b0;
            else if (!logged) begin
                req_log.push_back(bus_req);
                logged = 1'b1;
            end
            if (bus_reqcyc && reset && grant_left > 0) begin
                line = bus_req;
                grant_left--;
                repeat (2) begin
                    @(negedge clk);
                    chk("req_stable", bus_req, line);
                end
                bus_reqack = 1'b1;
                @(negedge clk);
                bus_reqack = 1'b0;
                logged = 1'b0;
                chk("reqcyc_drop", 64'(bus_reqcyc), 64'd0);
                b = 0;
                while (b < 8 && reset) begin
                    if (hold_on && b == hold_beat) begin
                        bus_respcyc = 1'b0;
                        paused = 1'b1;
                    end else begin
                        paused = 1'b0;
                        bus_respcyc = 1'b1;
                        bus_resp = {word(line + 64'(b * 8 + 4)), word(line + 64'(b * 8))};
                    end
                    #1;
                    if (bus_respcyc && bus_respack) begin
                        b++;
                        acked++;
                    end
                    @(negedge clk);
                end
                bus_respcyc = 1'b0;
                paused = 1'b0;
            end
        end
    end

    initial begin
        int viol;
        int base;
        reset = 1'b0;
        entry = 64'h1000;
        out_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;

        // Reset state
        tick();
        chk("rst_reqcyc", 64'(bus_reqcyc), 64'd0);
        chk("rst_respack", 64'(bus_respack), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_halt", 64'(halt), 64'd0);
        chk("rst_bus_req", bus_req, 64'd0);
        chk("rst_out_pc", out_pc, 64'd0);
        chk("rst_reqtag", 64'(bus_reqtag), 64'h1100);

        // Aligned entry, full line then next line address
        do_reset(64'h1000);
        grant_left = 1;
        out_ready = 1'b1;
        push_exp(64'h1000, 16);
        tick();
        chk("t1_req_latency", 64'(bus_reqcyc), 64'd1);
        chk("t1_bus_req", bus_req, 64'h1000);
        wait_q_empty("t1_drain");
        wait_reqs("t1_second_req", 2);
        chk("t1_next_line", req_log[1], 64'h1040);

        // Mid-line entry
        do_reset(64'h1008);
        grant_left = 1;
        out_ready = 1'b1;
        push_exp(64'h1008, 14);
        wait_reqs("t2_req", 1);
        chk("t2_bus_req", req_log[0], 64'h1000);
        wait_q_empty("t2_drain");

        // Back-pressure: full FIFO blocks the next request
        do_reset(64'h1000);
        grant_left = 1;
        wait_acked("t3_line_in", 8);
        viol = 0;
        repeat (100) begin
            tick();
            if (bus_reqcyc) viol++;
        end
        chk("t3_no_req_while_full", 64'(viol), 64'd0);
        chk("t3_valid_held", 64'(out_valid), 64'd1);
        chk("t3_head_pc", out_pc, 64'h1000);
        push_exp(64'h1000, 16);
        out_ready = 1'b1;
        wait_reqs("t3_second_req", 2);
        chk("t3_pops_before_req", 64'(pops), 64'd16);
        chk("t3_next_line", req_log[1], 64'h1040);
        wait_q_empty("t3_drain");

        // Redirect mid-response
        do_reset(64'h1000);
        hold_on = 1'b1;
        hold_beat = 3;
        grant_left = 2;
        wait_paused("t4_paused");
        redirect_valid = 1'b1;
        redirect_pc = 64'h2006;
        tick();
        redirect_valid = 1'b0;
        chk("t4_flushed", 64'(out_valid), 64'd0);
        base = acked;
        hold_on = 1'b0;
        push_exp(64'h2004, 15);
        out_ready = 1'b1;
        wait_reqs("t4_second_req", 2);
        chk("t4_drained_beats", 64'(acked - base), 64'd5);
        chk("t4_redirect_line", req_log[1], 64'h2000);
        wait_q_empty("t4_drain");

        // Halt on zero word, then redirect out of it
        zero_addr = 64'h1010;
        do_reset(64'h1000);
        grant_left = 1;
        out_ready = 1'b1;
        push_exp(64'h1000, 4);
        wait_q_empty("t5_pre_halt");
        wait_acked("t5_line_acked", 8);
        repeat (3) tick();
        chk("t5_halt", 64'(halt), 64'd1);
        chk("t5_valid_blocked", 64'(out_valid), 64'd0);
        repeat (50) tick();
        chk("t5_no_more_req", 64'(req_log.size()), 64'd1);
        grant_left = 1;
        redirect_valid = 1'b1;
        redirect_pc = 64'h3000;
        tick();
        redirect_valid = 1'b0;
        chk("t5_halt_cleared", 64'(halt), 64'd0);
        push_exp(64'h3000, 16);
        wait_q_empty("t5_refetch");
        chk("t5_refetch_line", req_log[1], 64'h3000);
        zero_addr = 64'h1;

        // Asynchronous reset in the middle of a response
        do_reset(64'h1000);
        grant_left = 1;
        wait_acked("t6_mid_resp", 4);
        reset = 1'b0;
        #1;
        chk("t6_reqcyc", 64'(bus_reqcyc), 64'd0);
        chk("t6_respack", 64'(bus_respack), 64'd0);
        chk("t6_out_valid", 64'(out_valid), 64'd0);
        chk("t6_halt", 64'(halt), 64'd0);
        entry = 64'h5040;
        tick();
        tick();
        exp_q.delete();
        req_log.delete();
        reset = 1'b1;
        wait_reqs("t6_req", 1);
        chk("t6_entry_line", req_log[0], 64'h5040);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
